led_pattern_gen: RTL and testbench

Multi-channel LED indicator generator, the parametrised successor to the single-output 1 Hz configuration blinker. It drives `P_N_CH` LED outputs. Each channel can be set at runtime to OFF, ON, BLINK or BURST, with a programmable half-period in milliseconds. It sits at top level next to the board LED pins and is configured by control logic through a one-cycle write strobe. After reset, channel 0 blinks at 1 Hz, so the FPGA-configured indication needs no configuration.

---
 rtl/led_pattern_pkg.sv | 41 ++++
 rtl/led_pattern_gen_if.sv | 30 +++
 rtl/led_pattern_chan.sv | 136 +++++++++++++
 rtl/led_pattern_gen.sv | 64 ++++++
 tb/tb_led_pattern_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared types, widths and helpers for led_pattern_gen.
// LED_PATTERN_ACTIVE_LOW_EN selects active-low LED drive polarity.
package led_pattern_pkg;

  localparam int HALF_W     = 16;
  localparam int BURST_W    = 4;
  localparam int GAP_HALVES = 4;

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PH_ON  = 2'd0,
    PH_OFF = 2'd1,
    PH_GAP = 2'd2
  } phase_e;

  typedef struct packed {
    mode_e              mode;
    logic [HALF_W-1:0]  half;
    logic [BURST_W-1:0] burst;
  } chan_cfg_t;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: config write strobe bundle plus LED/tick outputs.
// master = control logic side, slave = led_pattern_gen side.
interface led_pattern_gen_if #(
  parameter int P_N_CH = 4
);
  import led_pattern_pkg::*;

  localparam int CH_W = (P_N_CH > 1) ? clogb2(P_N_CH) : 1;

  logic               cfg_wr;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [HALF_W-1:0]  cfg_half;
  logic [BURST_W-1:0] cfg_burst;
  logic [P_N_CH-1:0]  led_out;
  logic               tick;

  modport master (
    output cfg_wr, cfg_ch, cfg_mode,
    output cfg_half, cfg_burst,
    input  led_out, tick
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_mode,
    input  cfg_half, cfg_burst,
    output led_out, tick
  );

endinterface

// File: rtl/led_pattern_chan.sv
// led_pattern_chan: one LED channel (config regs, half-period counter, burst FSM).
// Ports: clk, rst_n, tick_i, wr_i, cfg_i (mode/half/burst), led_o (registered drive).
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter logic              P_IS_CH0   = 1'b0,
  parameter logic [HALF_W-1:0] P_RST_HALF = 16'd1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick_i,
  input  logic      wr_i,
  input  chan_cfg_t cfg_i,
  output logic      led_o
);

  mode_e              mode_q, mode_d;
  phase_e             ph_q, ph_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [HALF_W-1:0]  cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               led_q, led_d;

  logic [HALF_W-1:0]  hm1;
  logic [BURST_W-1:0] pinc;
  logic               expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (P_IS_CH0) mode_q <= MODE_BLINK;
      else          mode_q <= MODE_OFF;
      half_q  <= P_RST_HALF;
      burst_q <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      ph_q    <= PH_ON;
      led_q   <= LED_INV;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      ph_q    <= ph_d;
      led_q   <= led_d;
    end
  end

  // led_q holds the physical pin level, so a toggle is
  // polarity-agnostic and only fixed levels need LED_INV.
  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    ph_d    = ph_q;
    led_d   = led_q;
    expire  = 1'b0;
    pinc    = pcnt_q + 1'b1;
    // half = 0 counts like half = 1
    hm1     = (half_q == '0) ? '0 : half_q - 1'b1;

    if (wr_i) begin
      mode_d  = cfg_i.mode;
      half_d  = cfg_i.half;
      burst_d = cfg_i.burst;
      cnt_d   = '0;
      pcnt_d  = '0;
      ph_d    = PH_ON;
      unique case (cfg_i.mode)
        MODE_OFF:   led_d = LED_INV;
        MODE_BURST: led_d = (cfg_i.burst == '0) ?
                            LED_INV : ~LED_INV;
        default:    led_d = ~LED_INV;
      endcase
    end else if (tick_i) begin
      if (cnt_q == hm1) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end

      unique case (1'b1)
        (mode_q == MODE_OFF): led_d = LED_INV;
        (mode_q == MODE_ON):  led_d = ~LED_INV;
        (mode_q == MODE_BLINK): begin
          if (expire) led_d = ~led_q;
        end
        (mode_q == MODE_BURST): begin
          if (burst_q == '0) begin
            led_d = LED_INV;
          end else if (expire) begin
            unique case (ph_q)
              PH_ON: begin
                ph_d  = PH_OFF;
                led_d = LED_INV;
              end
              PH_OFF: begin
                if (pinc == burst_q) begin
                  ph_d   = PH_GAP;
                  pcnt_d = '0;
                  led_d  = LED_INV;
                end else begin
                  ph_d   = PH_ON;
                  pcnt_d = pinc;
                  led_d  = ~LED_INV;
                end
              end
              PH_GAP: begin
                // pulse counter is reused to count gap halves
                if (pcnt_q == BURST_W'(GAP_HALVES - 1)) begin
                  ph_d   = PH_ON;
                  pcnt_d = '0;
                  led_d  = ~LED_INV;
                end else begin
                  pcnt_d = pinc;
                end
              end
              default: begin
                ph_d   = PH_ON;
                pcnt_d = '0;
              end
            endcase
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared tick prescaler plus P_N_CH pattern channels.
// Ports: clk, rst_n (async, active low), bus (led_pattern_gen_if.slave).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 100000000,
  parameter int P_TICK_HZ     = 1000,
  parameter int P_N_CH        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  led_pattern_gen_if.slave  bus
);

  localparam int N_TICK = P_CLK_FREQ_HZ / P_TICK_HZ;
  localparam int CNT_W  = clogb2(N_TICK);
  localparam int CH_W   = (P_N_CH > 1) ? clogb2(P_N_CH) : 1;
  localparam int RST_H  = (P_TICK_HZ / 2 < 1) ? 1 : P_TICK_HZ / 2;

  logic [CNT_W-1:0]  pre_q, pre_d;
  logic              tick_q, tick_d;
  logic [P_N_CH-1:0] led;
  chan_cfg_t         cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    tick_d = (pre_q == CNT_W'(N_TICK - 1));
    pre_d  = tick_d ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    cfg.mode  = mode_e'(bus.cfg_mode);
    cfg.half  = bus.cfg_half;
    cfg.burst = bus.cfg_burst;
  end

  // Out-of-range cfg_ch matches no channel, so the write drops.
  for (genvar i = 0; i < P_N_CH; i++) begin : g_ch
    led_pattern_chan #(
      .P_IS_CH0   (i == 0),
      .P_RST_HALF (HALF_W'(RST_H))
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick_q),
      .wr_i   (bus.cfg_wr && (bus.cfg_ch == CH_W'(i))),
      .cfg_i  (cfg),
      .led_o  (led[i])
    );
  end

  assign bus.led_out = led;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized + directed bench against an arithmetic model.
// Second 3-channel instance exercises the out-of-range channel rule.
module tb_led_pattern_gen;

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.P_N_CH(4)) bus ();
  led_pattern_gen_if #(.P_N_CH(3)) bus3 ();

  led_pattern_gen #(
    .P_CLK_FREQ_HZ(1000), .P_TICK_HZ(100), .P_N_CH(4)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  led_pattern_gen #(
    .P_CLK_FREQ_HZ(1000), .P_TICK_HZ(100), .P_N_CH(3)
  ) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Model: t = ticks counted since last write; LED level is a
  // pure function of t, half and burst.
  int m_cyc;
  bit m_tick;
  int m_mode[4];
  int m_h[4];
  int m_b[4];
  int m_t[4];
  bit m_st[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_tick <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_mode[c] <= (c == 0) ? 2 : 0;
        m_h[c]    <= (c == 0) ? 50 : 1;
        m_b[c]    <= 0;
        m_t[c]    <= 0;
        m_st[c]   <= 1'b0;
      end
    end else begin
      m_cyc  <= m_cyc + 1;
      m_tick <= ((m_cyc + 1) % 10 == 0);
      for (int c = 0; c < 4; c++) begin
        if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
          m_mode[c] <= int'(bus.cfg_mode);
          m_h[c]    <= (bus.cfg_half == 0) ? 1 : int'(bus.cfg_half);
          m_b[c]    <= int'(bus.cfg_burst);
          m_t[c]    <= 0;
          m_st[c]   <= 1'b1;
        end else if (m_tick) begin
          m_t[c] <= m_t[c] + 1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_led();
    logic [3:0] r;
    int p;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      case (m_mode[c])
        0: r[c] = 1'b0;
        1: r[c] = 1'b1;
        2: r[c] = m_st[c] ^ (((m_t[c] / m_h[c]) % 2) == 1);
        default: begin
          if (m_b[c] == 0) r[c] = 1'b0;
          else begin
            p = (m_t[c] / m_h[c]) % (2 * m_b[c] + 4);
            r[c] = (p < 2 * m_b[c]) && (p % 2 == 0);
          end
        end
      endcase
    end
    return r ^ INV;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int mode,
                    input int half, input int burst);
    bus.cfg_ch    = 2'(ch);
    bus.cfg_mode  = 2'(mode);
    bus.cfg_half  = 16'(half);
    bus.cfg_burst = 4'(burst);
    bus.cfg_wr    = 1'b1;
    cyc();
    bus.cfg_wr    = 1'b0;
  endtask

  task automatic wr3(input int ch, input int mode);
    bus3.cfg_ch    = 2'(ch);
    bus3.cfg_mode  = 2'(mode);
    bus3.cfg_half  = 16'd1;
    bus3.cfg_burst = 4'd0;
    bus3.cfg_wr    = 1'b1;
    cyc();
    bus3.cfg_wr    = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_n = 1'b0;
    #23;
    checks++;
    if (bus.led_out !== INV) begin
      failures++;
      $display("FAIL reset_led got=%b exp=%b", bus.led_out, INV);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", bus.tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 1200; k++) begin
      cyc();
      checks++;
      if (bus.tick !== (k % 10 == 0)) begin
        failures++;
        $display("FAIL tick_period k=%0d got=%b", k, bus.tick);
      end
      e = {3'b000, 1'(((k - 1) / 500) % 2)} ^ INV;
      checks++;
      if (bus.led_out !== e) begin
        failures++;
        $display("FAIL reset_blink k=%0d got=%b exp=%b",
                 k, bus.led_out, e);
      end
    end
  endtask

  task automatic test_on_off();
    wr(1, 1, 1, 0);
    checks++;
    if (bus.led_out[1] !== (1'b1 ^ INV[1])) begin
      failures++;
      $display("FAIL ch1_on got=%b", bus.led_out[1]);
    end
    cyc();
    wr(1, 0, 1, 0);
    checks++;
    if (bus.led_out[1] !== INV[1]) begin
      failures++;
      $display("FAIL ch1_off got=%b", bus.led_out[1]);
    end
    checks++;
    if (bus.led_out !== exp_led()) begin
      failures++;
      $display("FAIL on_off_model got=%b exp=%b",
               bus.led_out, exp_led());
    end
  endtask

  task automatic test_blink(input int half, input int lo,
                            input int hi, input int per);
    logic prev;
    int n;
    wr(2, 2, half, 0);
    checks++;
    if (bus.led_out[2] !== (1'b1 ^ INV[2])) begin
      failures++;
      $display("FAIL blink_start h=%0d got=%b", half, bus.led_out[2]);
    end
    for (int p = 0; p < 4; p++) begin
      prev = bus.led_out[2];
      n = 0;
      for (int i = 1; i <= per + 10 && n == 0; i++) begin
        cyc();
        checks++;
        if (bus.led_out !== exp_led()) begin
          failures++;
          $display("FAIL blink_model h=%0d got=%b exp=%b",
                   half, bus.led_out, exp_led());
        end
        if (bus.led_out[2] !== prev) n = i;
      end
      checks++;
      if (p == 0 && (n < lo || n > hi)) begin
        failures++;
        $display("FAIL blink_first h=%0d got=%0d exp=%0d..%0d",
                 half, n, lo, hi);
      end else if (p != 0 && n != per) begin
        failures++;
        $display("FAIL blink_period h=%0d got=%0d exp=%0d",
                 half, n, per);
      end
    end
  endtask

  task automatic test_burst();
    logic s[400];
    int highs, rises, bad, run, maxlo, maxhi;
    wr(3, 3, 2, 3);
    for (int j = 0; j < 400; j++) begin
      if (j > 0) cyc();
      s[j] = bus.led_out[3] ^ INV[3];
      checks++;
      if (bus.led_out !== exp_led()) begin
        failures++;
        $display("FAIL burst_model j=%0d got=%b exp=%b",
                 j, bus.led_out, exp_led());
      end
    end
    highs = 0; rises = 0; bad = 0;
    for (int j = 0; j < 200; j++) begin
      if (s[j]) highs++;
      if (j > 0 && s[j] && !s[j-1]) rises++;
      if (s[j] != s[j+200]) bad++;
    end
    if (s[200] && !s[199]) rises++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL burst_repeat got=%0d diffs exp=0", bad);
    end
    checks++;
    if (highs != 60) begin
      failures++;
      $display("FAIL burst_highs got=%0d exp=60", highs);
    end
    checks++;
    if (rises != 3) begin
      failures++;
      $display("FAIL burst_pulses got=%0d exp=3", rises);
    end
    maxlo = 0; maxhi = 0; run = 0;
    for (int j = 1; j < 400; j++) begin
      run = (s[j] == s[j-1]) ? run + 1 : 1;
      if (j > 30 && s[j] && run > maxhi) maxhi = run;
      if (!s[j] && run > maxlo) maxlo = run;
    end
    checks++;
    if (maxlo != 100 || maxhi != 20) begin
      failures++;
      $display("FAIL burst_runs lo=%0d hi=%0d exp=100/20",
               maxlo, maxhi);
    end
  endtask

  task automatic test_half_max();
    wr(1, 2, 16'hFFFF, 0);
    for (int i = 0; i < 300; i++) begin
      cyc();
      checks++;
      if (bus.led_out[1] !== (1'b1 ^ INV[1])) begin
        failures++;
        $display("FAIL half_max i=%0d got=%b", i, bus.led_out[1]);
      end
    end
  endtask

  task automatic test_out_of_range();
    wr3(1, 1);
    checks++;
    if (bus3.led_out[2:1] !== (2'b01 ^ INV[2:1])) begin
      failures++;
      $display("FAIL oor_setup got=%b", bus3.led_out[2:1]);
    end
    wr3(3, 0);
    cyc();
    checks++;
    if (bus3.led_out[2:1] !== (2'b01 ^ INV[2:1])) begin
      failures++;
      $display("FAIL oor_off got=%b", bus3.led_out[2:1]);
    end
    wr3(3, 1);
    cyc();
    checks++;
    if (bus3.led_out[2:1] !== (2'b01 ^ INV[2:1])) begin
      failures++;
      $display("FAIL oor_on got=%b", bus3.led_out[2:1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        wr($urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 4), $urandom_range(0, 4));
      else
        cyc();
      checks++;
      if (bus.led_out !== exp_led() || bus.tick !== m_tick) begin
        failures++;
        $display("FAIL random i=%0d led=%b exp=%b tick=%b exp=%b",
                 i, bus.led_out, exp_led(), bus.tick, m_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(3, 3, 2, 3);
    repeat (55) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.led_out !== INV || bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led=%b exp=%b tick=%b",
               bus.led_out, INV, bus.tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      cyc();
      checks++;
      if (bus.led_out !== exp_led()) begin
        failures++;
        $display("FAIL post_reset_model k=%0d got=%b exp=%b",
                 k, bus.led_out, exp_led());
      end
      checks++;
      if (bus.led_out[3] !== INV[3] ||
          bus.led_out[0] !== ((k > 500) ^ INV[0])) begin
        failures++;
        $display("FAIL post_reset k=%0d got=%b", k, bus.led_out);
      end
    end
  endtask

  initial begin
    bus.cfg_wr = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_mode = '0;
    bus.cfg_half = '0;
    bus.cfg_burst = '0;
    bus3.cfg_wr = 1'b0;
    bus3.cfg_ch = '0;
    bus3.cfg_mode = '0;
    bus3.cfg_half = '0;
    bus3.cfg_burst = '0;
    test_reset();
    test_on_off();
    test_blink(3, 21, 30, 30);
    test_burst();
    test_blink(0, 1, 10, 10);
    test_half_max();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
